mem_req_master: RTL and testbench



---
 rtl/mem_req_master_pkg.sv | 20 ++
 rtl/mem_req_master.sv | 176 +++++++++++++++++
 tb/tb_mem_req_master.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_master_pkg.sv
// Shared definitions for the Memory request sequencer: state encodings and defaults.
package mem_req_master_pkg;

   // Word-index bits decoded by the data Memory.
   localparam int unsigned MRM_ADDR_W = 10;

   typedef enum logic [2:0] {
      MRM_IDLE      = 3'd0,
      MRM_RD        = 3'd1,
      MRM_WR_SETUP  = 3'd2,
      MRM_WR_STROBE = 3'd3,
      MRM_WR_HOLD   = 3'd4,
      MRM_RESP      = 3'd5
   } mrm_state_e;

   function automatic int unsigned mrm_max(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/mem_req_master.sv
// Initiator-side sequencer for the asynchronous data Memory: one request in, one
// strobe sequence out with setup/hold around the strobe, one response back.
module mem_req_master
   import mem_req_master_pkg::*;
#(
   parameter int unsigned ADDR_W   = MRM_ADDR_W,
   parameter int unsigned RD_WAIT  = 1,
   parameter int unsigned WR_PULSE = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_ren,
   output logic        mem_wen,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   input  logic [31:0] mem_dout
);

   localparam int unsigned CNT_W = $clog2(mrm_max(RD_WAIT, WR_PULSE)) + 1;

   if (RD_WAIT < 1 || WR_PULSE < 1) begin : g_param_check
      $error("mem_req_master: RD_WAIT and WR_PULSE must both be >= 1");
   end

   mrm_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req_ready_q, req_ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_err_q, rsp_err_d;
   logic [31:0]      rsp_rdata_q, rsp_rdata_d;
   logic             mem_ren_q, mem_ren_d;
   logic             mem_wen_q, mem_wen_d;
   logic [31:0]      mem_addr_q, mem_addr_d;
   logic [31:0]      mem_din_q, mem_din_d;
   logic             addr_err;

   // Any set bit above the decoded word index means the Memory cannot be addressed.
   assign addr_err = |(req_addr >> ADDR_W);

   // Next-state and registered-output decode; every output is a flop.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      mem_ren_d   = mem_ren_q;
      mem_wen_d   = mem_wen_q;
      mem_addr_d  = mem_addr_q;
      mem_din_d   = mem_din_q;

      unique case (state_q)
         MRM_IDLE: begin
            if (req_valid) begin
               req_ready_d = 1'b0;
               if (addr_err) begin
                  // No strobe and no change of mem_addr/mem_din for a rejected request.
                  state_d     = MRM_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
               end else if (req_we) begin
                  state_d    = MRM_WR_SETUP;
                  mem_addr_d = req_addr;
                  mem_din_d  = req_wdata;
               end else begin
                  // mem_din deliberately left alone on reads.
                  state_d    = MRM_RD;
                  mem_addr_d = req_addr;
                  mem_ren_d  = 1'b1;
                  cnt_d      = CNT_W'(RD_WAIT - 1);
               end
            end
         end

         MRM_RD: begin
            if (cnt_q == '0) begin
               state_d     = MRM_RESP;
               mem_ren_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = mem_dout;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         MRM_WR_SETUP: begin
            state_d   = MRM_WR_STROBE;
            mem_wen_d = 1'b1;
            cnt_d     = CNT_W'(WR_PULSE - 1);
         end

         MRM_WR_STROBE: begin
            if (cnt_q == '0) begin
               state_d   = MRM_WR_HOLD;
               mem_wen_d = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         MRM_WR_HOLD: begin
            state_d     = MRM_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
         end

         MRM_RESP: begin
            if (rsp_ready) begin
               state_d     = MRM_IDLE;
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               req_ready_d = 1'b1;
            end
         end

         default: begin
            state_d     = MRM_IDLE;
            req_ready_d = 1'b1;
            rsp_valid_d = 1'b0;
            rsp_err_d   = 1'b0;
            mem_ren_d   = 1'b0;
            mem_wen_d   = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops the strobes without a clock edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= MRM_IDLE;
         cnt_q       <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         mem_ren_q   <= 1'b0;
         mem_wen_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         mem_ren_q   <= mem_ren_d;
         mem_wen_q   <= mem_wen_d;
         mem_addr_q  <= mem_addr_d;
         mem_din_q   <= mem_din_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mem_ren   = mem_ren_q;
   assign mem_wen   = mem_wen_q;
   assign mem_addr  = mem_addr_q;
   assign mem_din   = mem_din_q;

endmodule

// File: tb/tb_mem_req_master.sv
// Bench for mem_req_master: two instances (RD_WAIT/WR_PULSE = 1/1 and 3/2), each with its
// own asynchronous memory model, driven through a shared request bus and a selector.
module tb_mem_req_master;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
      bit          we;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        sel = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_ready = 1'b0;

   logic        vld_w [2];
   logic        rdy_w [2];
   logic        req_ready_w [2];
   logic        rsp_valid_w [2];
   logic [31:0] rsp_rdata_w [2];
   logic        rsp_err_w [2];
   logic        mem_ren_w [2];
   logic        mem_wen_w [2];
   logic [31:0] mem_addr_w [2];
   logic [31:0] mem_din_w [2];
   logic [31:0] mem_dout_w [2];

   logic [31:0] mem_m0 [1024] = '{default: 32'h0};
   logic [31:0] mem_m1 [1024] = '{default: 32'h0};
   logic [31:0] shadow0 [1024] = '{default: 32'h0};
   logic [31:0] shadow1 [1024] = '{default: 32'h0};

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clock = ~clock;

   assign vld_w[0] = req_valid & ~sel;
   assign vld_w[1] = req_valid & sel;
   assign rdy_w[0] = rsp_ready & ~sel;
   assign rdy_w[1] = rsp_ready & sel;

   assign mem_dout_w[0] = mem_m0[mem_addr_w[0][9:0]];
   assign mem_dout_w[1] = mem_m1[mem_addr_w[1][9:0]];

   // Memory models: a word is written on each clock edge seen with wen high.
   always @(posedge clock) if (mem_wen_w[0]) mem_m0[mem_addr_w[0][9:0]] <= mem_din_w[0];
   always @(posedge clock) if (mem_wen_w[1]) mem_m1[mem_addr_w[1][9:0]] <= mem_din_w[1];

   mem_req_master #(.ADDR_W(10), .RD_WAIT(1), .WR_PULSE(1)) u_dut1 (
      .clock(clock), .reset(reset),
      .req_valid(vld_w[0]), .req_ready(req_ready_w[0]), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid_w[0]), .rsp_ready(rdy_w[0]), .rsp_rdata(rsp_rdata_w[0]),
      .rsp_err(rsp_err_w[0]), .mem_ren(mem_ren_w[0]), .mem_wen(mem_wen_w[0]),
      .mem_addr(mem_addr_w[0]), .mem_din(mem_din_w[0]), .mem_dout(mem_dout_w[0])
   );

   mem_req_master #(.ADDR_W(10), .RD_WAIT(3), .WR_PULSE(2)) u_dut3 (
      .clock(clock), .reset(reset),
      .req_valid(vld_w[1]), .req_ready(req_ready_w[1]), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid_w[1]), .rsp_ready(rdy_w[1]), .rsp_rdata(rsp_rdata_w[1]),
      .rsp_err(rsp_err_w[1]), .mem_ren(mem_ren_w[1]), .mem_wen(mem_wen_w[1]),
      .mem_addr(mem_addr_w[1]), .mem_din(mem_din_w[1]), .mem_dout(mem_dout_w[1])
   );

   // Strobe invariants on both instances, sampled mid-cycle.
   logic        p_ren [2];
   logic        p_wen [2];
   logic [31:0] p_addr [2];
   logic [31:0] p_din [2];

   always @(negedge clock) begin
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            checks++;
            if (mem_ren_w[k] & mem_wen_w[k]) begin
               errors++;
               $display("FAIL strobe_overlap dut%0d: ren=%0b wen=%0b want not both", k,
                        mem_ren_w[k], mem_wen_w[k]);
            end
            // wen must rise only after a setup cycle; ren may rise with its address.
            if (mem_wen_w[k] || (mem_ren_w[k] && p_ren[k])) begin
               checks++;
               if (mem_addr_w[k] !== p_addr[k] || mem_din_w[k] !== p_din[k]) begin
                  errors++;
                  $display("FAIL strobe_stable dut%0d: addr=%h din=%h want addr=%h din=%h",
                           k, mem_addr_w[k], mem_din_w[k], p_addr[k], p_din[k]);
               end
            end
            p_ren[k]  = mem_ren_w[k];
            p_wen[k]  = mem_wen_w[k];
            p_addr[k] = mem_addr_w[k];
            p_din[k]  = mem_din_w[k];
         end else begin
            p_ren[k]  = 1'b0;
            p_wen[k]  = 1'b0;
            p_addr[k] = '0;
            p_din[k]  = '0;
         end
      end
   end

   // One full request/response transaction with scoreboard push at drive and pop at response.
   task automatic do_req(input bit s, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input int hold);
      exp_t        e;
      exp_t        g;
      int          rdw, wrp, c, nren, nwen, fren, fwen;
      bit          seen;
      logic [31:0] saddr, rd0;
      logic        er0;
      rdw = s ? 3 : 1;
      wrp = s ? 2 : 1;
      nren = 0; nwen = 0; fren = 0; fwen = 0; seen = 0; saddr = '0;
      @(negedge clock);
      sel = s;
      #1;
      checks++;
      if (req_ready_w[s] !== 1'b1) begin
         errors++;
         $display("FAIL req_ready_idle dut%0d: got %b want 1", s, req_ready_w[s]);
      end
      e.we  = we;
      e.err = (addr[31:10] != 0);
      if (e.err) begin
         e.rdata = '0;
         e.lat   = 1;
      end else if (we) begin
         e.rdata = '0;
         e.lat   = wrp + 3;
         if (s) shadow1[addr[9:0]] = wd;
         else   shadow0[addr[9:0]] = wd;
      end else begin
         e.rdata = s ? shadow1[addr[9:0]] : shadow0[addr[9:0]];
         e.lat   = rdw + 1;
      end
      sb_q.push_back(e);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
      @(posedge clock);
      #1 req_valid = 1'b0;
      c = 0;
      while (c < 40 && !seen) begin
         @(negedge clock);
         c++;
         if (mem_ren_w[s]) begin nren++; if (fren == 0) begin fren = c; saddr = mem_addr_w[s]; end end
         if (mem_wen_w[s]) begin nwen++; if (fwen == 0) begin fwen = c; saddr = mem_addr_w[s]; end end
         if (rsp_valid_w[s]) seen = 1;
      end
      g = sb_q.pop_front();
      checks++;
      if (!seen || c != g.lat) begin
         errors++;
         $display("FAIL rsp_latency dut%0d addr=%h we=%0b: got cycle %0d (seen=%0b) want %0d",
                  s, addr, we, c, seen, g.lat);
      end
      checks++;
      if (rsp_err_w[s] !== g.err || rsp_rdata_w[s] !== g.rdata) begin
         errors++;
         $display("FAIL rsp_data dut%0d addr=%h: got err=%b rdata=%h want err=%b rdata=%h",
                  s, addr, rsp_err_w[s], rsp_rdata_w[s], g.err, g.rdata);
      end
      checks++;
      if (g.err) begin
         if (nren != 0 || nwen != 0) begin
            errors++;
            $display("FAIL err_no_strobe dut%0d: got ren=%0d wen=%0d cycles want 0", s, nren,
                     nwen);
         end
      end else if (g.we) begin
         if (nren != 0 || nwen != wrp || fwen != 2 || saddr !== addr) begin
            errors++;
            $display("FAIL wr_strobe dut%0d: got wen=%0d first=%0d addr=%h want %0d 2 %h",
                     s, nwen, fwen, saddr, wrp, addr);
         end
      end else begin
         if (nwen != 0 || nren != rdw || fren != 1 || saddr !== addr) begin
            errors++;
            $display("FAIL rd_strobe dut%0d: got ren=%0d first=%0d addr=%h want %0d 1 %h",
                     s, nren, fren, saddr, rdw, addr);
         end
      end
      rd0 = rsp_rdata_w[s];
      er0 = rsp_err_w[s];
      for (int i = 0; i < hold; i++) begin
         // A competing request during backpressure must be ignored.
         req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
         @(negedge clock);
         checks++;
         if (rsp_valid_w[s] !== 1'b1 || rsp_rdata_w[s] !== rd0 || rsp_err_w[s] !== er0 ||
             req_ready_w[s] !== 1'b0) begin
            errors++;
            $display("FAIL rsp_hold dut%0d: got v=%b d=%h e=%b rdy=%b want 1 %h %b 0", s,
                     rsp_valid_w[s], rsp_rdata_w[s], rsp_err_w[s], req_ready_w[s], rd0, er0);
         end
      end
      rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      checks++;
      if (rsp_valid_w[s] !== 1'b0 || rsp_err_w[s] !== 1'b0 || req_ready_w[s] !== 1'b1) begin
         errors++;
         $display("FAIL rsp_done dut%0d: got v=%b e=%b rdy=%b want 0 0 1", s,
                  rsp_valid_w[s], rsp_err_w[s], req_ready_w[s]);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clock);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (req_ready_w[k] !== 1'b1 || rsp_valid_w[k] !== 1'b0 || rsp_err_w[k] !== 1'b0 ||
             rsp_rdata_w[k] !== 32'h0 || mem_ren_w[k] !== 1'b0 || mem_wen_w[k] !== 1'b0 ||
             mem_addr_w[k] !== 32'h0 || mem_din_w[k] !== 32'h0) begin
            errors++;
            $display("FAIL reset_state dut%0d: rdy=%b v=%b e=%b d=%h ren=%b wen=%b a=%h di=%h",
                     k, req_ready_w[k], rsp_valid_w[k], rsp_err_w[k], rsp_rdata_w[k],
                     mem_ren_w[k], mem_wen_w[k], mem_addr_w[k], mem_din_w[k]);
         end
      end
      reset = 1'b1;
   endtask

   task automatic test_basic_rw();
      do_req(1'b0, 1'b1, 32'h4, 32'hDEADBEEF, 0);
      do_req(1'b0, 1'b0, 32'h4, 32'h0, 0);
      do_req(1'b1, 1'b1, 32'h3FF, 32'h12345678, 0);
      do_req(1'b1, 1'b0, 32'h3FF, 32'h0, 0);
   endtask

   task automatic test_addr_err();
      for (int k = 0; k < 2; k++) begin
         do_req(k[0], 1'b0, 32'h400, 32'h0, 0);
         do_req(k[0], 1'b1, 32'h400, 32'hCAFEF00D, 0);
         // Word 0 is where a wrapped out-of-range write would land.
         do_req(k[0], 1'b0, 32'h0, 32'h0, 0);
      end
   endtask

   task automatic test_backpressure();
      do_req(1'b0, 1'b0, 32'h4, 32'h0, 5);
      do_req(1'b1, 1'b1, 32'h3FF, 32'h0BADC0DE, 5);
      do_req(1'b1, 1'b0, 32'h3FF, 32'h0, 0);
   endtask

   task automatic test_reset_mid_write();
      bit got_wen;
      got_wen = 0;
      @(negedge clock);
      sel = 1'b0;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5;
      @(posedge clock);
      #1 req_valid = 1'b0;
      for (int i = 0; i < 10 && !got_wen; i++) begin
         @(negedge clock);
         got_wen = mem_wen_w[0];
      end
      checks++;
      if (!got_wen) begin
         errors++;
         $display("FAIL reset_mid_wen_seen: got no mem_wen want mem_wen high");
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (mem_wen_w[0] !== 1'b0 || mem_ren_w[0] !== 1'b0 || rsp_valid_w[0] !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: got wen=%b ren=%b v=%b want 0 0 0", mem_wen_w[0],
                  mem_ren_w[0], rsp_valid_w[0]);
      end
      @(negedge clock);
      reset = 1'b1;
      shadow0[10'h20] = mem_m0[10'h20];
      #1;
      checks++;
      if (req_ready_w[0] !== 1'b1 || rsp_valid_w[0] !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got rdy=%b v=%b want 1 0", req_ready_w[0],
                  rsp_valid_w[0]);
      end
      do_req(1'b0, 1'b0, 32'h4, 32'h0, 0);
   endtask

   task automatic test_random();
      bit          s, we;
      logic [31:0] addr;
      for (int i = 0; i < 500; i++) begin
         s  = 1'($urandom_range(0, 1));
         we = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) addr = $urandom | 32'h400;
         else                            addr = 32'($urandom_range(0, 63));
         do_req(s, we, addr, $urandom, int'($urandom_range(0, 2)));
      end
   endtask

   initial begin
      test_reset();
      test_basic_rw();
      test_addr_err();
      test_backpressure();
      test_reset_mid_write();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
